// File: rtl/adpcm_pkg.sv
// Shared types and constants for the ADPCM code packer: code/word typedefs, the FIFO entry
// layout and the framing FSM states.
package adpcm_pkg;

  localparam int unsigned NIBS_PER_WORD = 4;

  typedef logic [3:0]  code_t;
  typedef logic [15:0] word_t;

  typedef struct packed {
    logic  last;
    word_t word;
  } pack_entry_t;

  typedef enum logic [0:0] {
    S_HDR,
    S_PAY
  } state_e;

endpackage

// File: rtl/adpcm_sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset and full/empty/level flags.
// A push while full is only taken when a pop happens in the same cycle.
module adpcm_sync_fifo #(
  parameter int unsigned Width = 17,
  parameter int unsigned Depth = 8,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned LvlW  = AddrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LvlW-1:0]  level_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, wptr_d;
  logic [AddrW-1:0] rptr_q, rptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    pop_ok  = pop_i && !empty_o;
    push_ok = push_i && (!full_o || pop_ok);
    wptr_d  = push_ok ? wptr_q + AddrW'(1) : wptr_q;
    rptr_d  = pop_ok ? rptr_q + AddrW'(1) : rptr_q;
    level_d = level_q + LvlW'(push_ok) - LvlW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/adpcm_code_packer.sv
// Packs four 4-bit ADPCM codes per 16-bit word, buffers words and frames them behind a
// {SYNC_BYTE, seq} header. Define ADPCM_PACK_DROP_CNT_EN to add the drop_cnt output.
module adpcm_code_packer
  import adpcm_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned FRAME_WORDS = 16,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            code_valid,
  input  code_t           code,
  input  logic            flush,
  output logic            out_valid,
  output word_t           out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic [LvlW-1:0] fifo_level,
  output logic            overflow
`ifdef ADPCM_PACK_DROP_CNT_EN
  ,
  output logic [15:0]     drop_cnt
`endif
);

  localparam logic [7:0]  LastIdx = 8'(FRAME_WORDS - 1);
  localparam int unsigned EntryW  = $bits(pack_entry_t);

  logic [1:0]  nib_cnt_q, nib_cnt_d;
  word_t       word_q, word_d, cur_word;
  logic        push, pop, drop;
  pack_entry_t push_entry, head;
  logic        fifo_full, fifo_empty;

  state_e      state_q, state_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  pay_cnt_q, pay_cnt_d;
  logic        out_valid_q, out_valid_d;
  word_t       out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        overflow_q, overflow_d;
  logic        load_en, pay_last;

  // The first nibble clears the rest of the word, so flush padding is already zero.
  always_comb begin
    cur_word   = word_q;
    nib_cnt_d  = nib_cnt_q;
    push       = 1'b0;
    push_entry = '0;
    if (code_valid) begin
      unique case (nib_cnt_q)
        2'd0:    cur_word = {code, 12'h000};
        2'd1:    cur_word[11:8] = code;
        2'd2:    cur_word[7:4] = code;
        default: cur_word[3:0] = code;
      endcase
      nib_cnt_d = nib_cnt_q + 2'd1;
    end
    word_d = cur_word;
    if (code_valid && (nib_cnt_q == 2'(NIBS_PER_WORD - 1))) begin
      push       = 1'b1;
      push_entry = '{last: flush, word: cur_word};
    end else if (flush && (nib_cnt_d != 2'd0)) begin
      push       = 1'b1;
      push_entry = '{last: 1'b1, word: cur_word};
      nib_cnt_d  = 2'd0;
    end
  end

  adpcm_sync_fifo #(
    .Width(EntryW),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (reset),
    .push_i (push),
    .wdata_i(push_entry),
    .pop_i  (pop),
    .rdata_o(head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(fifo_level)
  );

  assign drop     = push && fifo_full && !pop;
  assign load_en  = !out_valid_q || out_ready;
  assign pay_last = (pay_cnt_q == LastIdx) || head.last;

  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    pay_cnt_d   = pay_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    overflow_d  = overflow_q | drop;
    pop         = 1'b0;
    if (load_en) begin
      // With nothing to load the register simply empties; data/last keep their old value.
      out_valid_d = 1'b0;
      unique case (state_q)
        S_HDR: begin
          if (!fifo_empty) begin
            out_valid_d = 1'b1;
            out_data_d  = {SYNC_BYTE, seq_q};
            out_last_d  = 1'b0;
            pay_cnt_d   = '0;
            state_d     = S_PAY;
          end
        end
        default: begin
          if (!fifo_empty) begin
            pop         = 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = head.word;
            out_last_d  = pay_last;
            pay_cnt_d   = pay_cnt_q + 8'd1;
            if (pay_last) begin
              seq_d   = seq_q + 8'd1;
              state_d = S_HDR;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      nib_cnt_q   <= '0;
      word_q      <= '0;
      state_q     <= S_HDR;
      seq_q       <= '0;
      pay_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      nib_cnt_q   <= nib_cnt_d;
      word_q      <= word_d;
      state_q     <= state_d;
      seq_q       <= seq_d;
      pay_cnt_q   <= pay_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;

`ifdef ADPCM_PACK_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_adpcm_code_packer.sv
// Bench for adpcm_code_packer: three instances (FRAME_WORDS 2, 1, 16) share stimulus and are
// checked against a stream-level model of words and frames. Honors ADPCM_PACK_DROP_CNT_EN.
module tb_adpcm_code_packer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic code_valid = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b0;
  logic [3:0] code = 4'h0;

  logic [2:0]         ov, ol, ovf;
  logic [2:0][15:0]   od;
  logic [2:0][LW-1:0] lvl;
`ifdef ADPCM_PACK_DROP_CNT_EN
  logic [2:0][15:0]   dcnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adpcm_code_packer #(.FIFO_DEPTH(DEPTH), .FRAME_WORDS(2), .SYNC_BYTE(8'hA5)) u_dut_fw2 (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code(code), .flush(flush),
    .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]), .out_ready(out_ready),
    .fifo_level(lvl[0]), .overflow(ovf[0])
`ifdef ADPCM_PACK_DROP_CNT_EN
    , .drop_cnt(dcnt[0])
`endif
  );

  adpcm_code_packer #(.FIFO_DEPTH(DEPTH), .FRAME_WORDS(1), .SYNC_BYTE(8'hA5)) u_dut_fw1 (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code(code), .flush(flush),
    .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]), .out_ready(out_ready),
    .fifo_level(lvl[1]), .overflow(ovf[1])
`ifdef ADPCM_PACK_DROP_CNT_EN
    , .drop_cnt(dcnt[1])
`endif
  );

  adpcm_code_packer #(.FIFO_DEPTH(DEPTH), .FRAME_WORDS(16), .SYNC_BYTE(8'hA5)) u_dut_fw16 (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code(code), .flush(flush),
    .out_valid(ov[2]), .out_data(od[2]), .out_last(ol[2]), .out_ready(out_ready),
    .fifo_level(lvl[2]), .overflow(ovf[2])
`ifdef ADPCM_PACK_DROP_CNT_EN
    , .drop_cnt(dcnt[2])
`endif
  );

  // Reference model: expected accepted words per instance as {last, data}.
  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [16:0] q2[$];
  int          seq_m [3];
  int          cnt_m [3];
  bit          in_frame [3];
  logic [15:0] nib_word = 16'h0;
  int          nib_n = 0;
  int          model_cap = -1;
  int          model_pushed = 0;

  function automatic int fw_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic int q_size(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic q_push(input int k, input logic [16:0] v);
    case (k)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic q_pop(input int k, output logic [16:0] v, output bit ok);
    ok = (q_size(k) > 0);
    v  = '0;
    if (ok) begin
      case (k)
        0:       v = q0.pop_front();
        1:       v = q1.pop_front();
        default: v = q2.pop_front();
      endcase
    end
  endtask

  task automatic model_word(input logic [15:0] w, input logic last);
    logic l;
    if (model_cap >= 0 && model_pushed >= model_cap) return;
    model_pushed++;
    for (int k = 0; k < 3; k++) begin
      if (!in_frame[k]) begin
        q_push(k, {1'b0, 8'hA5, 8'(seq_m[k])});
        in_frame[k] = 1'b1;
        cnt_m[k]    = 0;
      end
      l = last || (cnt_m[k] == fw_of(k) - 1);
      q_push(k, {l, w});
      cnt_m[k]++;
      if (l) begin
        seq_m[k]    = (seq_m[k] + 1) % 256;
        in_frame[k] = 1'b0;
      end
    end
  endtask

  task automatic model_input(input logic cv, input logic [3:0] c, input logic fl);
    bit done = 1'b0;
    if (cv) begin
      nib_word = nib_word | (16'(c) << (4 * (3 - nib_n)));
      nib_n++;
      if (nib_n == 4) begin
        model_word(nib_word, fl);
        nib_word = 16'h0;
        nib_n    = 0;
        done     = 1'b1;
      end
    end
    if (fl && !done && nib_n > 0) begin
      model_word(nib_word, 1'b1);
      nib_word = 16'h0;
      nib_n    = 0;
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    q2.delete();
    for (int k = 0; k < 3; k++) begin
      seq_m[k]    = 0;
      cnt_m[k]    = 0;
      in_frame[k] = 1'b0;
    end
    nib_word     = 16'h0;
    nib_n        = 0;
    model_pushed = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic cv, input logic [3:0] c, input logic fl);
    code_valid = cv;
    code       = c;
    flush      = fl;
    if (reset) model_input(cv, c, fl);
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    flush      = 1'b0;
    code       = 4'h0;
  endtask

  task automatic idle();
    cycle(1'b0, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    code_valid = 1'b0;
    flush      = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_valid%0d", k), 32'(ov[k]), 32'd0);
      chk($sformatf("rst_last%0d", k), 32'(ol[k]), 32'd0);
      chk($sformatf("rst_data%0d", k), 32'(od[k]), 32'd0);
      chk($sformatf("rst_level%0d", k), 32'(lvl[k]), 32'd0);
      chk($sformatf("rst_ovf%0d", k), 32'(ovf[k]), 32'd0);
`ifdef ADPCM_PACK_DROP_CNT_EN
      chk($sformatf("rst_dcnt%0d", k), 32'(dcnt[k]), 32'd0);
`endif
    end
    reset = 1'b1;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (q_size(0) == 0 && q_size(1) == 0 && q_size(2) == 0 && ov == 3'b000) break;
      idle();
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_left%0d", name, k), 32'(q_size(k)), 32'd0);
    end
  endtask

  // Transfer and hold monitor, sampled on the falling edge.
  logic [2:0]       stall_q = 3'b000;
  logic [2:0][16:0] held_q;
  logic [16:0]      mon_v;
  bit               mon_ok;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset && stall_q[k]) begin
        chk($sformatf("hold%0d", k), 32'({ov[k], ol[k], od[k]}), 32'({1'b1, held_q[k]}));
      end
      if (reset && ov[k] && out_ready) begin
        q_pop(k, mon_v, mon_ok);
        if (!mon_ok) begin
          checks++;
          errors++;
          $display("FAIL xfer%0d: got unexpected word %0h expected none", k, {ol[k], od[k]});
        end else begin
          chk($sformatf("xfer%0d", k), 32'({ol[k], od[k]}), 32'(mon_v));
        end
      end
      stall_q[k] <= reset && ov[k] && !out_ready;
      held_q[k]  <= {ol[k], od[k]};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        cv;
    logic [3:0]  c;
    logic        fl;
    logic        ev;
    logic [15:0] ed;
    logic        el;
    int          elvl;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // Per-cycle expectations for the FRAME_WORDS=2 instance straight out of reset.
    tbl[0]  = '{1'b1, 4'h1, 1'b0, 1'b0, 16'h0000, 1'b0, 0};
    tbl[1]  = '{1'b1, 4'h2, 1'b0, 1'b0, 16'h0000, 1'b0, 0};
    tbl[2]  = '{1'b1, 4'h3, 1'b0, 1'b0, 16'h0000, 1'b0, 0};
    tbl[3]  = '{1'b1, 4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1};
    tbl[4]  = '{1'b0, 4'h0, 1'b0, 1'b1, 16'hA500, 1'b0, 1};
    tbl[5]  = '{1'b0, 4'h0, 1'b0, 1'b1, 16'h1234, 1'b0, 0};
    tbl[6]  = '{1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 0};
    tbl[7]  = '{1'b1, 4'h5, 1'b0, 1'b0, 16'h0000, 1'b0, 0};
    tbl[8]  = '{1'b1, 4'h6, 1'b0, 1'b0, 16'h0000, 1'b0, 0};
    tbl[9]  = '{1'b1, 4'h7, 1'b0, 1'b0, 16'h0000, 1'b0, 0};
    tbl[10] = '{1'b1, 4'h8, 1'b0, 1'b0, 16'h0000, 1'b0, 1};
    tbl[11] = '{1'b0, 4'h0, 1'b0, 1'b1, 16'h5678, 1'b1, 0};
    tbl[12] = '{1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 0};

    model_reset();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].cv, tbl[i].c, tbl[i].fl);
      chk($sformatf("tbl%0d_valid", i), 32'(ov[0]), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_level", i), 32'(lvl[0]), 32'(tbl[i].elvl));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), 32'(od[0]), 32'(tbl[i].ed));
        chk($sformatf("tbl%0d_last", i), 32'(ol[0]), 32'(tbl[i].el));
      end
    end
    drain("tbl");

    // Two-word frames, codes 0..7.
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i), 1'b0);
    drain("frame2");

    // Flush variants: partial word, completing code with flush, lone code with flush, idle flush.
    cycle(1'b1, 4'h9, 1'b0);
    cycle(1'b1, 4'hA, 1'b0);
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b1, 4'h1, 1'b0);
    cycle(1'b1, 4'h2, 1'b0);
    cycle(1'b1, 4'h3, 1'b0);
    cycle(1'b1, 4'h4, 1'b1);
    cycle(1'b1, 4'hB, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    drain("flush");

    // Overflow: 10 words arrive with the sink stalled; only the first DEPTH survive.
    do_reset();
    out_ready = 1'b0;
    model_cap = int'(DEPTH);
    for (int i = 0; i < 4 * (int'(DEPTH) + 2); i++) cycle(1'b1, 4'(i), 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ovf_level%0d", k), 32'(lvl[k]), 32'(DEPTH));
      chk($sformatf("ovf_flag%0d", k), 32'(ovf[k]), 32'd1);
`ifdef ADPCM_PACK_DROP_CNT_EN
      chk($sformatf("ovf_dcnt%0d", k), 32'(dcnt[k]), 32'd2);
`endif
    end
    model_cap = -1;
    drain("ovf");
    for (int k = 0; k < 3; k++) chk($sformatf("ovf_sticky%0d", k), 32'(ovf[k]), 32'd1);

    // 257 single-word frames: header sequence wraps 0xFF -> 0x00.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      cycle(1'b1, 4'(i), 1'b1);
      idle();
    end
    drain("wrap");

    // Reset with 3 words buffered and 2 nibbles pending.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 14; i++) cycle(1'b1, 4'(i + 3), 1'b0);
    for (int k = 0; k < 3; k++) chk($sformatf("pre_rst_level%0d", k), 32'(lvl[k]), 32'd3);
    do_reset();
    out_ready = 1'b1;
    cycle(1'b1, 4'h5, 1'b0);
    cycle(1'b1, 4'h6, 1'b0);
    cycle(1'b1, 4'h7, 1'b0);
    cycle(1'b1, 4'h8, 1'b0);
    idle();
    chk("post_rst_hdr", 32'({ov[0], od[0]}), 32'({1'b1, 16'hA500}));
    idle();
    chk("post_rst_pay", 32'({ov[0], od[0]}), 32'({1'b1, 16'h5678}));
    drain("post_rst");

    // Randomized traffic with a mostly-ready sink.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      out_ready = (($urandom % 8) != 0);
      cycle(1'($urandom % 2), 4'($urandom), 1'(($urandom % 32) == 0));
    end
    drain("rand");
    for (int k = 0; k < 3; k++) chk($sformatf("rand_ovf%0d", k), 32'(ovf[k]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adpcm_code_packer.md
Name: adpcm_code_packer

Overview:
- Sits directly downstream of `encoder`. Consumes its 4-bit ADPCM code stream, one code per `clk` when `code_valid` is high.
- Packs four codes into one 16-bit word and buffers the words in a small FIFO.
- Emits framed words on a valid/ready stream for a byte/word transport. Each frame is one header word plus up to FRAME_WORDS payload words.

Parameters:
- FIFO_DEPTH, 8: payload FIFO depth in words; must be a power of 2 and at least 2.
- FRAME_WORDS, 16: payload words per frame; range 1..255.
- SYNC_BYTE, 8'hA5: upper byte of every header word.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- code_valid  in  1  `code` is valid this cycle.
- code  in  4  ADPCM code from `encoder`.
- flush  in  1  pad the partial word and end the current frame on it.
- out_valid  out  1  `out_data` holds a word.
- out_data  out  16  header or payload word.
- out_last  out  1  final word of the frame.
- out_ready  in  1  downstream accepts the word when `out_valid` and `out_ready` are both high.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of words currently in the FIFO.
- overflow  out  1  sticky flag: a word was dropped.

Behaviour:
- Reset (reset==0 at an edge):
  - `out_valid`, `out_last`, `overflow` and `fifo_level` go to 0; `out_data` goes to 16'h0000.
  - nib_cnt=0, seq=0, FSM enters S_HDR.
  - Any partial word and all FIFO contents are discarded.
  - Reset mid-frame simply abandons the frame; no `out_last` is emitted.
- Nibble assembly:
  - The first code of a word goes in [15:12], the fourth in [3:0].
  - nib_cnt counts 0..3 and wraps.
  - On the 4th code, {last=0, word} is pushed into the FIFO (17-bit entries).
- Flush:
  - flush=1 with nib_cnt>0: remaining nibbles are zero-padded and {last=1, word} is pushed; nib_cnt returns to 0.
  - If code_valid is also high in the same cycle, that code is included before padding.
  - If that code completes the word, the word is pushed with last=1 and no padding is applied.
  - flush with nib_cnt==0 and no code_valid is ignored.
- FIFO:
  - A push when full with no pop in the same cycle drops the word and sets `overflow` (held until reset).
  - A push when full with a simultaneous pop is accepted.
  - A pop when empty never occurs.
- Output register: loads whenever it is empty or is being consumed (out_valid & out_ready). `out_data` and `out_last` stay stable while out_valid & !out_ready.
- Framing FSM:
  - S_HDR: once the FIFO is non-empty, load {SYNC_BYTE, seq} with last=0, clear pay_cnt, go to S_PAY. A header is never sent without at least one payload word buffered.
  - S_PAY: load the FIFO head and increment pay_cnt.
    - out_last = (pay_cnt==FRAME_WORDS-1) | entry.last.
    - When out_last is loaded: seq <= seq+1 (wraps 255->0), go to S_HDR.
    - If the FIFO is empty, wait in S_PAY; out_valid drops once the current word is consumed.
- Latency: with out_ready=1, the 4th code of the first word sampled at edge N gives:
  - FIFO entry written at edge N;
  - header visible from edge N+1;
  - payload word visible from edge N+2.
- Throughput: sustained codes produce 1 word per 4 cycles plus 1 header per frame, so the FIFO cannot overflow while out_ready stays high.

Optional Feature:
- Macro ADPCM_PACK_DROP_CNT_EN.
- Defined: extra output port `drop_cnt[15:0]` counts every dropped word, saturating at 16'hFFFF; reset to 0.
- Undefined: the port and counter do not exist; only the sticky `overflow` flag remains.

Decomposition:
- Package `adpcm_pkg` holds:
  - the code_t (logic [3:0]) and word_t (logic [15:0]) typedefs;
  - the pack entry struct {last, word};
  - the FSM state enum {S_HDR, S_PAY};
  - the NIBS_PER_WORD=4 constant.
- One sub-module, `adpcm_sync_fifo` (parameterised width/depth, synchronous active-low reset, full/empty/level outputs), instantiated for the word buffer.

Test Plan:
- Codes 1,2,3,4 with out_ready=1 -> out_data 16'hA500 (out_last=0), then 16'h1234 (out_last=1 only if FRAME_WORDS=1).
- FRAME_WORDS=2, 8 codes 0..7 -> 16'hA500, 16'h0123, 16'h4567 (out_last=1); next frame header 16'hA501.
- Codes 9,A then flush -> payload 16'h9A00 with out_last=1; seq increments.
- out_ready=0 while 4*(FIFO_DEPTH+2) codes arrive -> fifo_level saturates at FIFO_DEPTH; overflow=1; the first FIFO_DEPTH words emerge intact once out_ready=1.
- 256 frames with FRAME_WORDS=1 -> header seq runs 00..FF then wraps to 16'hA500.
- reset=0 mid-frame with 2 nibbles pending and 3 words buffered -> next cycle out_valid=0, fifo_level=0; subsequent codes 5,6,7,8 yield 16'hA500, 16'h5678.
